// File: rtl/bus_arb_if.sv
// Requester/memory-side bundle for bus_arb. The slave modport is the arbiter's
// view. The master modport is the view of the requesters plus the memory read port.
interface bus_arb_if #(
    parameter int NREQ      = 2,
    parameter int AD_LEN    = 32,
    parameter int BUS_WIDTH = 32
);
    logic [NREQ-1:0]        req_i;
    logic [NREQ*AD_LEN-1:0] ad_i;
    logic [NREQ-1:0]        gnt_o;
    logic [AD_LEN-1:0]      bus_ad_o;
    logic [BUS_WIDTH-1:0]   bus_data_i;
    logic [BUS_WIDTH-1:0]   data_o;
    logic [NREQ-1:0]        data_valid_o;

    modport master (
        output req_i, ad_i, bus_data_i,
        input  gnt_o, bus_ad_o, data_o, data_valid_o
    );

    modport slave (
        input  req_i, ad_i, bus_data_i,
        output gnt_o, bus_ad_o, data_o, data_valid_o
    );
endinterface

// File: rtl/bus_arb.sv
// Round-robin PE memory bus arbiter with a per-tenure beat limit.
// A read-return pipeline tags each read with the requester that issued it.
// Optional macro BUS_ARB_LOCK_EN adds lock_i, which suppresses the beat-limit preemption.
module bus_arb #(
    parameter int NREQ      = 2,
    parameter int AD_LEN    = 32,
    parameter int BUS_WIDTH = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_HOLD  = 8
) (
    input  logic      clk_i,
    input  logic      reset_i,
`ifdef BUS_ARB_LOCK_EN
    input  logic [NREQ-1:0] lock_i,
`endif
    bus_arb_if.slave  bus
);
    localparam int          IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR  = NREQ;
    localparam int unsigned RL  = RD_LAT;

    typedef enum logic [1:0] {IDLE, OWN, ARB} state_t;

    state_t            state, state_n;
    logic [IDW-1:0]    ptr, ptr_n, owner, owner_n;
    logic [7:0]        hold, hold_n;
    logic [NREQ-1:0]   gnt_q, gnt_n, own_mask;
    logic [AD_LEN-1:0] bus_ad_q, own_ad;
    logic [IDW-1:0]    win;
    logic              win_found;
    logic              own_req, others, lock_owner, preempt, beat;
    logic              iss_v;
    logic [IDW-1:0]    iss_id;
    logic [RD_LAT-1:0] pv;
    logic [IDW-1:0]    pid [RD_LAT];

    // Round-robin search: first requester above the last owner, wrapping
    always_comb begin
        logic [IDW-1:0] cand;
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = IDW'((32'(ptr) + i) % NR);
            if (!win_found && bus.req_i[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    // Owner view: its request, address, competitors and preemption condition
    always_comb begin
        own_mask = NREQ'(1) << owner;
        own_req  = bus.req_i[owner];
        others   = |(bus.req_i & ~own_mask);
        own_ad   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (owner == IDW'(k)) own_ad = bus.ad_i[k*AD_LEN +: AD_LEN];
        end
`ifdef BUS_ARB_LOCK_EN
        lock_owner = lock_i[owner];
`else
        lock_owner = 1'b0;
`endif
        preempt = (hold == 8'(MAX_HOLD)) && others && !lock_owner;
        beat    = (state == OWN) && own_req && !preempt;
    end

    // Next-state, grant and hold-counter logic
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold;
        gnt_n   = '0;
        case (state)
            IDLE, ARB: begin
                if (win_found) begin
                    state_n = OWN;
                    owner_n = win;
                    gnt_n   = NREQ'(1) << win;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN: begin
                if (beat) begin
                    gnt_n = own_mask;
                    if (hold != 8'(MAX_HOLD)) hold_n = hold + 8'd1;
                end else begin
                    state_n = ARB;
                    ptr_n   = owner;
                    hold_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Arbiter state, grant and bus address registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            ptr      <= IDW'(NREQ - 1);
            owner    <= '0;
            hold     <= '0;
            gnt_q    <= '0;
            bus_ad_q <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            hold  <= hold_n;
            gnt_q <= gnt_n;
            if (beat) bus_ad_q <= own_ad;
        end
    end

    // Read-return pipeline: iss_* tags the address now on the bus,
    // then RD_LAT stages carry it to the data-valid output
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            iss_v  <= 1'b0;
            iss_id <= '0;
            pv     <= '0;
            for (int unsigned i = 0; i < RL; i++) pid[i] <= '0;
        end else begin
            iss_v  <= beat;
            iss_id <= owner;
            pv[0]  <= iss_v;
            pid[0] <= iss_id;
            for (int unsigned i = 1; i < RL; i++) begin
                pv[i]  <= pv[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.bus_ad_o     = bus_ad_q;
    assign bus.data_o       = bus.bus_data_i;
    assign bus.data_valid_o = pv[RD_LAT-1] ? (NREQ'(1) << pid[RD_LAT-1]) : '0;
endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb (NREQ=2, RD_LAT=2, MAX_HOLD=8).
// Build with BUS_ARB_LOCK_EN defined to exercise the lock feature.
module tb_bus_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef BUS_ARB_LOCK_EN
    logic [1:0] lock = 2'b00;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    bus_arb_if #(.NREQ(2), .AD_LEN(32), .BUS_WIDTH(32)) bif ();

    bus_arb #(
        .NREQ(2), .AD_LEN(32), .BUS_WIDTH(32), .RD_LAT(2), .MAX_HOLD(8)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
`ifdef BUS_ARB_LOCK_EN
        .lock_i  (lock),
`endif
        .bus     (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [1:0]  req;
        logic [31:0] ad0;
        logic [31:0] ad1;
        logic [1:0]  gnt;
        logic [31:0] bad;
        logic [1:0]  dv;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: inputs applied after the falling edge, outputs sampled 1ns later
    task automatic drive(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1);
        logic [31:0] d;
        @(negedge clk);
        bif.req_i      = r;
        bif.ad_i       = {a1, a0};
        d              = $urandom;
        bif.bus_data_i = d;
        #1;
        chk("data_o", bif.data_o, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bif.req_i = '0;
        bif.ad_i  = '0;
`ifdef BUS_ARB_LOCK_EN
        lock = 2'b00;
`endif
        #1;
        chk("rst_gnt", bif.gnt_o, 0);
        chk("rst_dv", bif.data_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] eb;
        logic [1:0]  eg;
        int          dv0, dv1, p, t;

        bif.req_i      = '0;
        bif.ad_i       = '0;
        bif.bus_data_i = '0;
        #1;
        chk("init_gnt", bif.gnt_o, 0);
        chk("init_bad", bif.bus_ad_o, 0);
        chk("init_dv", bif.data_valid_o, 0);

        // Single owner, three beats; then owner 0 yields after three beats to requester 1
        vt.push_back('{1, 2'b01, 32'h100, 0, 2'b00, 32'h000, 2'b00});
        vt.push_back('{0, 2'b01, 32'h100, 0, 2'b01, 32'h000, 2'b00});
        vt.push_back('{0, 2'b01, 32'h104, 0, 2'b01, 32'h100, 2'b00});
        vt.push_back('{0, 2'b01, 32'h108, 0, 2'b01, 32'h104, 2'b00});
        vt.push_back('{0, 2'b00, 32'h000, 0, 2'b01, 32'h108, 2'b01});
        vt.push_back('{0, 2'b00, 32'h000, 0, 2'b00, 32'h108, 2'b01});
        vt.push_back('{0, 2'b00, 32'h000, 0, 2'b00, 32'h108, 2'b01});
        vt.push_back('{0, 2'b00, 32'h000, 0, 2'b00, 32'h108, 2'b00});
        vt.push_back('{1, 2'b11, 32'h100, 32'h200, 2'b00, 32'h000, 2'b00});
        vt.push_back('{0, 2'b11, 32'h100, 32'h200, 2'b01, 32'h000, 2'b00});
        vt.push_back('{0, 2'b11, 32'h104, 32'h200, 2'b01, 32'h100, 2'b00});
        vt.push_back('{0, 2'b11, 32'h108, 32'h200, 2'b01, 32'h104, 2'b00});
        vt.push_back('{0, 2'b10, 32'h000, 32'h200, 2'b01, 32'h108, 2'b01});
        vt.push_back('{0, 2'b10, 32'h000, 32'h200, 2'b00, 32'h108, 2'b01});
        vt.push_back('{0, 2'b10, 32'h000, 32'h200, 2'b10, 32'h108, 2'b01});
        vt.push_back('{0, 2'b00, 32'h000, 32'h200, 2'b10, 32'h200, 2'b00});
        vt.push_back('{0, 2'b00, 32'h000, 32'h200, 2'b00, 32'h200, 2'b00});
        vt.push_back('{0, 2'b00, 32'h000, 32'h200, 2'b00, 32'h200, 2'b10});
        vt.push_back('{0, 2'b00, 32'h000, 32'h200, 2'b00, 32'h200, 2'b00});

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            drive(vt[i].req, vt[i].ad0, vt[i].ad1);
            chk($sformatf("vec%0d_gnt", i), bif.gnt_o, vt[i].gnt);
            chk($sformatf("vec%0d_bad", i), bif.bus_ad_o, vt[i].bad);
            chk($sformatf("vec%0d_dv", i), bif.data_valid_o, vt[i].dv);
        end

        // Both requesting: 8-beat tenures alternating 0,1,0,1 with one dead cycle between
        do_reset();
        eb  = '0;
        dv0 = 0;
        dv1 = 0;
        for (int c = 0; c < 42; c++) begin
            drive(2'b11, 32'h1000 + c, 32'h2000 + c);
            p  = (c - 1) % 10;
            t  = (c - 1) / 10;
            eg = (c == 0 || p == 9) ? 2'b00 : ((t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_gnt_c%0d", c), bif.gnt_o, eg);
            chk($sformatf("rr_bad_c%0d", c), bif.bus_ad_o, eb);
            chk($sformatf("rr_dv_onehot_c%0d", c),
                bif.data_valid_o & (bif.data_valid_o - 2'd1), 0);
            dv0 += bif.data_valid_o[0];
            dv1 += bif.data_valid_o[1];
            if (c >= 1 && p < 8) eb = (t % 2 == 0) ? 32'h1000 + c : 32'h2000 + c;
        end
        for (int c = 0; c < 6; c++) begin
            drive(2'b00, 0, 0);
            dv0 += bif.data_valid_o[0];
            dv1 += bif.data_valid_o[1];
        end
        chk("rr_dv0_count", dv0, 17);
        chk("rr_dv1_count", dv1, 16);

        // Lone owner: no preemption past MAX_HOLD, 20 beats give 20 valids
        do_reset();
        dv0 = 0;
        for (int c = 0; c < 21; c++) begin
            drive(2'b01, 32'h3000 + c, 0);
            chk($sformatf("alone_gnt_c%0d", c), bif.gnt_o, (c == 0) ? 2'b00 : 2'b01);
            dv0 += bif.data_valid_o[0];
        end
        drive(2'b00, 0, 0);
        chk("alone_release_gnt", bif.gnt_o, 2'b01);
        dv0 += bif.data_valid_o[0];
        for (int c = 0; c < 5; c++) begin
            drive(2'b00, 0, 0);
            dv0 += bif.data_valid_o[0];
        end
        chk("alone_dv_count", dv0, 20);
        chk("alone_idle_gnt", bif.gnt_o, 2'b00);

        // Saturated owner, late competitor at cycle 12: released the next cycle
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive((c >= 12) ? 2'b11 : 2'b01, 32'h3000 + c, 32'h4000);
            eg = (c == 0 || c == 13) ? 2'b00 : ((c == 14) ? 2'b10 : 2'b01);
            chk($sformatf("late_gnt_c%0d", c), bif.gnt_o, eg);
            if (c == 13) chk("late_bad_c13", bif.bus_ad_o, 32'h3000 + 11);
        end

        // Reset with a beat in flight: outputs clear without an edge, no stale valid
        do_reset();
        drive(2'b01, 32'h500, 0);
        drive(2'b01, 32'h500, 0);
        drive(2'b00, 0, 0);
        chk("fly_bad_before", bif.bus_ad_o, 32'h500);
        chk("fly_gnt_before", bif.gnt_o, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("fly_gnt_async", bif.gnt_o, 0);
        chk("fly_bad_async", bif.bus_ad_o, 0);
        chk("fly_dv_async", bif.data_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(2'b00, 0, 0);
            chk($sformatf("fly_dv_after_c%0d", c), bif.data_valid_o, 0);
        end

`ifdef BUS_ARB_LOCK_EN
        // Locked owner keeps the bus past MAX_HOLD; unlocking releases it
        do_reset();
        lock = 2'b01;
        for (int c = 0; c < 15; c++) begin
            drive(2'b11, 32'h6000 + c, 32'h7000);
            chk($sformatf("lock_gnt_c%0d", c), bif.gnt_o, (c == 0) ? 2'b00 : 2'b01);
        end
        lock = 2'b00;
        drive(2'b11, 32'h6000, 32'h7000);
        chk("unlock_gnt_c15", bif.gnt_o, 2'b01);
        drive(2'b11, 32'h6000, 32'h7000);
        chk("unlock_gnt_c16", bif.gnt_o, 2'b00);
        drive(2'b11, 32'h6000, 32'h7000);
        chk("unlock_gnt_c17", bif.gnt_o, 2'b10);
        drive(2'b00, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Arbitrates the single PE memory bus between NREQ requesters, e.g. the fetch unit (req 0) and a load/store unit (req 1).
- Round-robin grant with a per-grant beat limit for fairness.
- Drives the registered bus address from the owner and returns read data to the issuing requester after a fixed memory latency.
- Sits between the requesters and the PE bus pins (bus_ad_o, bus_data_i).

Parameters:
- NREQ, 2, number of requesters (2..8)
- AD_LEN, 32, bus address width
- BUS_WIDTH, 32, bus data width
- RD_LAT, 1, cycles from address on bus_ad_o to valid data on bus_data_i (1..4)
- MAX_HOLD, 8, beats an owner may issue before forced release while others wait (2..255)

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- req_i  in  NREQ  per-requester bus request, level
- ad_i  in  NREQ*AD_LEN  per-requester address, slice k = [k*AD_LEN +: AD_LEN]
- gnt_o  out  NREQ  one-hot grant, registered
- bus_ad_o  out  AD_LEN  bus address, registered
- bus_data_i  in  BUS_WIDTH  bus read data
- data_o  out  BUS_WIDTH  read data to requesters (combinational copy of bus_data_i)
- data_valid_o  out  NREQ  one-hot: data_o belongs to requester k this cycle

Behaviour:
- Reset (reset_i=0, any time):
  - gnt_o=0, bus_ad_o=0, data_valid_o=0.
  - State goes to IDLE, last-owner pointer = NREQ-1, hold counter = 0.
  - Latency pipeline cleared; in-flight beats are dropped and never reported.
- States IDLE, OWN, ARB.
- IDLE:
  - gnt_o=0.
  - If any req_i bit is set, pick the first set bit searching upward from pointer+1 (mod NREQ).
  - gnt_o=onehot(winner) on the next edge -> OWN. Grant latency is 1 cycle.
- OWN (owner k):
  - A beat is any cycle with req_i[k]=1. On that edge bus_ad_o<=ad_i[k], and hold counter increments (saturating at MAX_HOLD).
  - bus_ad_o holds its value on non-beat cycles.
- Leaving OWN: if req_i[k]=0, or hold counter = MAX_HOLD while any other req_i bit is set (preemption):
  - That cycle is not a beat.
  - Next edge: gnt_o=0, pointer<=k, counter<=0, state -> ARB.
- Owner alone: at MAX_HOLD with no other requester, the owner keeps the grant and the counter stays saturated. A later competing request triggers release on the next cycle.
- ARB: one dead cycle with gnt_o=0, then arbitration exactly as in IDLE. If no request is pending, go to IDLE.
- Read data return:
  - A beat whose address is on bus_ad_o in cycle T sets data_valid_o[k]=1 in cycle T+RD_LAT.
  - Implemented as an RD_LAT-deep shift register of {valid, owner id}.
  - Valids stay tagged to the issuer even after the grant moves. Back-to-back beats give back-to-back valids.
- Requesters:
  - May drop req_i before they are granted; arbitration always uses current-cycle req_i.
  - Must hold ad_i stable only during beat cycles.
- At most one gnt_o bit and one data_valid_o bit are set in any cycle.

Optional Feature:
- Macro BUS_ARB_LOCK_EN.
- Defined: adds port lock_i in NREQ. While lock_i[owner]=1 the MAX_HOLD preemption is suppressed, and the owner releases only by dropping req_i.
- Not defined: no lock_i port; preemption at MAX_HOLD always applies.

Test Plan:
1. Reset then req_i=01, ad_i[0]=0x100 for 3 cycles:
   - gnt_o=01 one cycle after the request.
   - bus_ad_o=0x100 one cycle after the first beat.
   - data_valid_o=01 RD_LAT cycles after that, for 3 consecutive cycles.
2. req_i=11 held from reset:
   - Grant order 0, 1, 0, 1.
   - Each tenure is exactly MAX_HOLD=8 beats, with 1 dead cycle of gnt_o=00 between tenures.
3. Owner 0 drops req at its beat 3 while req_i[1]=1:
   - gnt_o=00 for one cycle, then gnt_o=10.
   - Valids for beats 1-3 arrive tagged 01 after the grant has switched.
4. req_i=01 alone for 20 cycles:
   - No preemption; 20 beats and 20 valids.
   - Raise req_i[1] at cycle 12: owner 0 is released the next cycle.
5. Reset asserted with 1 beat in flight (RD_LAT=2):
   - All outputs are 0 immediately, with no clock edge needed.
   - No data_valid_o pulse after reset is released.
6. With BUS_ARB_LOCK_EN, lock_i=01, req_i=11 for 15 cycles:
   - Requester 0 keeps the grant past 8 beats.
   - Clear lock_i: release to requester 1 within 2 cycles.
